// File: rtl/control_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// control_sequencer_pkg
//   Shared definitions between the instruction-cycle sequencer and the
//   decoder downstream of it.
//   - IW           : default instruction width
//   - seq_state_t  : 2-bit sequencer state as seen by the decoder
//                    (FETCH=00, EXEC1=01, EXEC2=10, HALT=11; all legal)
// ---------------------------------------------------------------------------
package control_sequencer_pkg;

  localparam int IW = 16;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC1 = 2'b01,
    ST_EXEC2 = 2'b10,
    ST_HALT  = 2'b11
  } seq_state_t;

endpackage

// File: rtl/control_sequencer_edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
//   Registered rising-edge detector. pulse is high for exactly one clock
//   cycle, the cycle after din is first sampled high.
//   Ports:
//     clk   : system clock
//     reset : asynchronous active-high reset (clears history and pulse)
//     din   : level input to watch
//     pulse : one-cycle registered rising-edge pulse
// ---------------------------------------------------------------------------
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= din;
      pulse <= din & ~prev;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//   Instruction-cycle sequencer plus instruction register (IR) feeding the
//   decoder. Walks FETCH -> EXEC1 [-> EXEC2] per instruction, parks in HALT
//   when there is nothing to run, and honours decoder stop requests.
//   Debug control: run (level), step (edge, one instruction per edge) and
//   resume (edge, clears the stop latch). Counts retired instructions.
//
//   Ports:
//     clk          : system clock, all state on rising edge
//     reset        : asynchronous active-high reset
//     instr_rdata  : instruction RAM read data, captured in FETCH
//     sm_extra     : decoder request for EXEC2 (looked at in EXEC1 only)
//     stop         : decoder halt request
//     run          : free-run enable (level)
//     step         : single-step request (rising edge)
//     resume       : clear stop latch (rising edge)
//     state        : sequencer state to decoder
//     instruction  : IR contents to decoder
//     halted       : state == HALT
//     stopped      : stop latch, set when halted by stop
//     instr_count  : retired-instruction count (wraps)
//
//   Handshake note: there is no valid/ready pair here. The decoder treats
//   state as a qualifier: instruction is meaningful in EXEC1/EXEC2 and is
//   held unchanged until the next FETCH edge.
// ---------------------------------------------------------------------------
module control_sequencer #(
  parameter int IW           = control_sequencer_pkg::IW,
  parameter int COUNT_W      = 16,
  parameter bit START_HALTED = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IW-1:0]      instr_rdata,
  input  logic               sm_extra,
  input  logic               stop,
  input  logic               run,
  input  logic               step,
  input  logic               resume,
  output logic [1:0]         state,
  output logic [IW-1:0]      instruction,
  output logic               halted,
  output logic               stopped,
  output logic [COUNT_W-1:0] instr_count
);

  import control_sequencer_pkg::*;

  localparam seq_state_t RESET_STATE = START_HALTED ? ST_HALT : ST_FETCH;

  seq_state_t state_q;
  seq_state_t state_d;
  logic       step_pulse;
  logic       resume_pulse;
  logic       step_credit;

  // Decode signals for the current cycle.
  logic step_set;   // a step edge that earns a credit this cycle
  logic go_hold;    // permission to leave HALT
  logic go_retire;  // permission to start the next instruction on retire
  logic retire;     // the current instruction completes at this edge
  logic stop_evt;   // decoder stop accepted this cycle

  edge_detect u_step_edge (
    .clk   (clk),
    .reset (reset),
    .din   (step),
    .pulse (step_pulse)
  );

  edge_detect u_resume_edge (
    .clk   (clk),
    .reset (reset),
    .din   (resume),
    .pulse (resume_pulse)
  );

  always_comb begin
    // Step edges are ignored while running (run already grants permission)
    // and discarded while stopped (no banking of credit across a stop).
    step_set  = step_pulse & ~stopped & ~run;
    go_hold   = ~stopped & (run | step_credit);
    // On a retiring edge the current credit is spent; only run or a fresh
    // step edge arriving in the very same cycle can continue without HALT.
    go_retire = ~stopped & (run | step_set);

    state_d  = state_q;
    retire   = 1'b0;
    stop_evt = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (stop) begin
          stop_evt = 1'b1;
          state_d  = ST_HALT;
        end else begin
          state_d  = ST_EXEC1;
        end
      end
      ST_EXEC1: begin
        if (stop) begin
          stop_evt = 1'b1;
          retire   = 1'b1;
          state_d  = ST_HALT;
        end else if (sm_extra) begin
          state_d  = ST_EXEC2;
        end else begin
          retire   = 1'b1;
          state_d  = go_retire ? ST_FETCH : ST_HALT;
        end
      end
      ST_EXEC2: begin
        retire = 1'b1;
        if (stop) begin
          stop_evt = 1'b1;
          state_d  = ST_HALT;
        end else begin
          state_d  = go_retire ? ST_FETCH : ST_HALT;
        end
      end
      ST_HALT: begin
        state_d = go_hold ? ST_FETCH : ST_HALT;
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      instruction <= '0;
      stopped     <= 1'b0;
      step_credit <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;

      // IR loads only on a FETCH that is not cancelled by stop, so it stays
      // stable through EXEC1/EXEC2 and is held across HALT.
      if (state_q == ST_FETCH && !stop) begin
        instruction <= instr_rdata;
      end

      // stop and resume cannot coincide in effect: stop is only accepted
      // outside HALT, and a latched stop keeps the sequencer in HALT.
      if (stop_evt) begin
        stopped <= 1'b1;
      end else if (resume_pulse) begin
        stopped <= 1'b0;
      end

      // A fresh step edge on a retiring edge re-arms the credit for the
      // next instruction instead of being lost to the consume.
      if (stop_evt) begin
        step_credit <= 1'b0;
      end else if (step_set) begin
        step_credit <= 1'b1;
      end else if (retire) begin
        step_credit <= 1'b0;
      end

      if (retire) begin
        instr_count <= instr_count + COUNT_W'(1);
      end
    end
  end

  assign state  = state_q;
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//   Directed bench for control_sequencer (COUNT_W=4 so the counter wraps
//   within a short run, START_HALTED=1). Every clock the expected
//   {state, halted, stopped, instr_count} tuple is queued before the edge
//   and compared just after it; IR and reset values are checked directly.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

  localparam int IW = 16;
  localparam int CW = 4;

  localparam logic [1:0] S_F  = 2'b00;
  localparam logic [1:0] S_E1 = 2'b01;
  localparam logic [1:0] S_E2 = 2'b10;
  localparam logic [1:0] S_H  = 2'b11;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [IW-1:0] instr_rdata;
  logic          sm_extra;
  logic          stop;
  logic          run;
  logic          step;
  logic          resume;
  logic [1:0]    state;
  logic [IW-1:0] instruction;
  logic          halted;
  logic          stopped;
  logic [CW-1:0] instr_count;

  control_sequencer #(
    .IW           (IW),
    .COUNT_W      (CW),
    .START_HALTED (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_rdata (instr_rdata),
    .sm_extra    (sm_extra),
    .stop        (stop),
    .run         (run),
    .step        (step),
    .resume      (resume),
    .state       (state),
    .instruction (instruction),
    .halted      (halted),
    .stopped     (stopped),
    .instr_count (instr_count)
  );

  // Scoreboard
  logic [7:0]    exp_q[$];
  logic [CW-1:0] exp_cnt;
  logic          exp_stp;
  int            n_vec = 0;
  int            n_err = 0;
  logic [IW-1:0] rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue the expectation for the coming edge, advance one clock, then
  // compare the DUT against the popped entry.
  task automatic cyc(input logic [1:0] s);
    logic [7:0] e;
    logic [7:0] o;
    exp_q.push_back({s, (s == S_H), exp_stp, exp_cnt});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = {state, halted, stopped, instr_count};
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL seq_%0d {state,halted,stopped,count}: observed %b expected %b", n_vec, o, e);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; resume = 1'b0;
    stop = 1'b0; sm_extra = 1'b0; instr_rdata = '0;
    exp_cnt = '0; exp_stp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",   32'(state), 32'(S_H));
    chk("rst_ir",      32'(instruction), 32'h0);
    chk("rst_count",   32'(instr_count), 32'h0);
    chk("rst_stopped", 32'(stopped), 32'h0);
    reset = 1'b0;
    cyc(S_H);

    // Free run: first instruction, then three more back to back.
    run = 1'b1; instr_rdata = 16'h1234;
    cyc(S_F);
    cyc(S_E1);
    chk("ir_first", 32'(instruction), 32'h1234);
    for (int i = 0; i < 3; i++) begin
      exp_cnt++;
      cyc(S_F);
      rd = 16'($urandom_range(0, 16'hFFFF));
      instr_rdata = rd;
      cyc(S_E1);
      chk("ir_run", 32'(instruction), 32'(rd));
    end

    // sm_extra instruction: three cycles, one count at EXEC2 exit.
    exp_cnt++;
    cyc(S_F);
    instr_rdata = 16'h6400;
    cyc(S_E1);
    chk("ir_extra", 32'(instruction), 32'h6400);
    sm_extra = 1'b1;
    cyc(S_E2);
    exp_cnt++;
    cyc(S_F);
    sm_extra = 1'b0;

    // Drop run: finish the current instruction then park in HALT.
    run = 1'b0; instr_rdata = 16'h0AAA;
    cyc(S_E1);
    exp_cnt++;
    cyc(S_H);
    cyc(S_H);
    chk("ir_hold_halt", 32'(instruction), 32'h0AAA);

    // Single step from HALT.
    step = 1'b1;
    cyc(S_H);
    step = 1'b0;
    cyc(S_H);
    cyc(S_F);
    cyc(S_E1);
    exp_cnt++;
    cyc(S_H);
    cyc(S_H);

    // Two step edges, second landing in the retiring EXEC1 cycle.
    step = 1'b1;
    cyc(S_H);
    step = 1'b0;
    cyc(S_H);
    cyc(S_F);
    step = 1'b1;
    cyc(S_E1);
    step = 1'b0;
    exp_cnt++;
    cyc(S_F);
    cyc(S_E1);
    exp_cnt++;
    cyc(S_H);
    cyc(S_H);
    cyc(S_H);

    // stop in EXEC1: retires, latches stopped, run cannot restart.
    run = 1'b1; instr_rdata = 16'hF010;
    cyc(S_F);
    cyc(S_E1);
    chk("ir_stp", 32'(instruction), 32'hF010);
    stop = 1'b1;
    exp_cnt++; exp_stp = 1'b1;
    cyc(S_H);
    stop = 1'b0;
    cyc(S_H);
    cyc(S_H);
    // Step while stopped is discarded, not banked.
    run = 1'b0; step = 1'b1;
    cyc(S_H);
    step = 1'b0;
    cyc(S_H);
    resume = 1'b1;
    cyc(S_H);
    resume = 1'b0; exp_stp = 1'b0;
    cyc(S_H);
    cyc(S_H);
    cyc(S_H);
    run = 1'b1;
    cyc(S_F);

    // stop in FETCH: no IR load, no count.
    stop = 1'b1; instr_rdata = 16'hBEEF; exp_stp = 1'b1;
    cyc(S_H);
    stop = 1'b0;
    chk("ir_fetch_stop", 32'(instruction), 32'hF010);

    // resume with run held: FETCH two cycles after the resume pulse.
    resume = 1'b1;
    cyc(S_H);
    resume = 1'b0; exp_stp = 1'b0;
    cyc(S_H);
    cyc(S_F);

    // stop and sm_extra together in EXEC1: stop wins.
    instr_rdata = 16'h6400;
    cyc(S_E1);
    sm_extra = 1'b1; stop = 1'b1;
    exp_cnt++; exp_stp = 1'b1;
    cyc(S_H);
    sm_extra = 1'b0; stop = 1'b0;
    resume = 1'b1;
    cyc(S_H);
    resume = 1'b0; exp_stp = 1'b0;
    cyc(S_H);
    cyc(S_F);

    // Sixteen instructions: the 4-bit counter passes 15 -> 0.
    for (int i = 0; i < 16; i++) begin
      rd = 16'($urandom_range(0, 16'hFFFF));
      instr_rdata = rd;
      cyc(S_E1);
      chk("ir_wrap", 32'(instruction), 32'(rd));
      exp_cnt++;
      cyc(S_F);
    end

    // Step edge while run=1 earns no credit.
    step = 1'b1;
    cyc(S_E1);
    step = 1'b0;
    exp_cnt++;
    cyc(S_F);
    run = 1'b0;
    cyc(S_E1);
    exp_cnt++;
    cyc(S_H);
    cyc(S_H);

    // Reset asserted in the middle of EXEC2.
    run = 1'b1; instr_rdata = 16'h6400;
    cyc(S_F);
    cyc(S_E1);
    sm_extra = 1'b1;
    cyc(S_E2);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_state",   32'(state), 32'(S_H));
    chk("mid_rst_count",   32'(instr_count), 32'h0);
    chk("mid_rst_ir",      32'(instruction), 32'h0);
    chk("mid_rst_stopped", 32'(stopped), 32'h0);
    exp_cnt = '0; exp_stp = 1'b0;
    run = 1'b0; sm_extra = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(S_H);
    run = 1'b1; instr_rdata = 16'h0055;
    cyc(S_F);
    cyc(S_E1);
    run = 1'b0;
    exp_cnt++;
    cyc(S_H);
    chk("ir_after_rst", 32'(instruction), 32'h0055);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
